// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, ALU width and FSM state encoding.
package alu_arbiter_pkg;

   localparam int ALU_DW = 32;

   // 4'b0101 and 4'b1111 are undefined; the ALU returns 0 for them.
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SLL  = 4'b0011,
      ALU_SRL  = 4'b0100,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_ADDU = 4'b1000,
      ALU_SUBU = 4'b1001,
      ALU_XOR  = 4'b1010,
      ALU_SLTU = 4'b1011,
      ALU_NOR  = 4'b1100,
      ALU_SRA  = 4'b1101,
      ALU_LUI  = 4'b1110
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at NREQ.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [NREQ-1:0] rot;
   logic [IW:0]     sum;

   always_comb begin
      // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
      rot = NREQ'({req, req} >> ptr);
      sum = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) sum = {1'b0, ptr} + (IW+1)'(k);
      end
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      gnt_idx = sum[IW-1:0];
      gnt     = '0;
      if (|req) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters: round-robin accept,
// registered operands, one EXEC cycle, then a held result per requester handshake.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = ALU_DW
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*4-1:0] req_ctrl,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [DW-1:0]     resp_w,
   output logic              resp_zero,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [3:0]        alu_ctrl,
   input  logic [DW-1:0]     alu_w,
   input  logic              alu_zero,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int IW = $clog2(NREQ);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // req_ready is offered only in IDLE, to the arbitration winner; resp_valid is held in
   // RESP for the granted requester until its resp_ready is seen.

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   grant;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;
   logic [3:0]      sel_ctrl;
   logic [NREQ-1:0] grant_oh;
   logic [IW-1:0]   next_ptr;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_ctrl = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_a    = req_a[i*DW +: DW];
            sel_b    = req_b[i*DW +: DW];
            sel_ctrl = req_ctrl[i*4 +: 4];
         end
      end
   end

   // Gated by Reset_n so req_ready drops immediately while reset is asserted.
   assign req_ready = (state == ST_IDLE && Reset_n) ? gnt : '0;
   assign grant_oh  = NREQ'(1) << grant;
   assign next_ptr  = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
   assign dbg_state = state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         grant      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= ALU_AND;
         resp_w     <= '0;
         resp_zero  <= 1'b0;
         resp_valid <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|(req_valid & req_ready)) begin
                  alu_a    <= sel_a;
                  alu_b    <= sel_b;
                  alu_ctrl <= sel_ctrl;
                  grant    <= gnt_idx;
                  busy     <= 1'b1;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_w     <= alu_w;
               resp_zero  <= alu_zero;
               resp_valid <= grant_oh;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               // Pointer moves only on completion so the next search starts past this winner.
               if (resp_ready[grant]) begin
                  resp_valid <= '0;
                  busy       <= 1'b0;
                  rr_ptr     <= next_ptr;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU model, directed steps and a randomized phase
// scored against an arbitration/result model.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int NREQ = 2;
   localparam int DW   = 32;

   logic              Clk = 1'b0;
   logic              Reset_n;
   logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [NREQ*DW-1:0] req_a, req_b;
   logic [NREQ*4-1:0] req_ctrl;
   logic [DW-1:0]     resp_w, alu_a, alu_b, alu_w;
   logic              resp_zero, alu_zero, busy;
   logic [3:0]        alu_ctrl;
   logic [1:0]        dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int m_ptr       = 0;
   logic [DW:0] exp_q[$];

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // ---------------- reference ALU: {zero, w} ----------------
   function automatic logic [DW:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [DW-1:0] w;
      case (op)
         ALU_AND:  w = a & b;
         ALU_OR:   w = a | b;
         ALU_ADD:  w = a + b;
         ALU_SLL:  w = b << a[4:0];
         ALU_SRL:  w = b >> a[4:0];
         ALU_SUB:  w = a - b;
         ALU_SLT:  w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_ADDU: w = a + b;
         ALU_SUBU: w = a - b;
         ALU_XOR:  w = a ^ b;
         ALU_SLTU: w = (a < b) ? 32'd1 : 32'd0;
         ALU_NOR:  w = ~(a | b);
         ALU_SRA:  w = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI:  w = b << 16;
         default:  w = '0;
      endcase
      return {(w == '0), w};
   endfunction

   assign {alu_zero, alu_w} = ref_alu(alu_ctrl, alu_a, alu_b);

   alu_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ctrl   (req_ctrl),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_w     (resp_w),
      .resp_zero  (resp_zero),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_w      (alu_w),
      .alu_zero   (alu_zero),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [NREQ-1:0] onehot(input int r);
      return NREQ'(1) << r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic apply_reset();
      Reset_n    = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      tick();
      tick();
      Reset_n = 1'b1;
      m_ptr   = 0;
   endtask

   task automatic set_req(input int r, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
      req_a[r*DW +: DW] = a;
      req_b[r*DW +: DW] = b;
      req_ctrl[r*4 +: 4] = op;
   endtask

   // Single-requester transaction with cycle-exact checks; called right after tick().
   task automatic run_op(input int r, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit pre, output logic [DW:0] res);
      logic [DW:0] exp;
      exp = ref_alu(op, a, b);
      set_req(r, op, a, b);
      req_valid     = onehot(r);
      resp_ready[r] = pre;
      #1;
      check("op_req_ready", 64'(req_ready), 64'(onehot(r)));
      tick();
      req_valid = '0;
      #1;
      check("op_exec_busy", 64'(busy), 64'd1);
      check("op_exec_no_resp", 64'(resp_valid), 64'd0);
      check("op_alu_a", 64'(alu_a), 64'(a));
      check("op_alu_b", 64'(alu_b), 64'(b));
      check("op_alu_ctrl", 64'(alu_ctrl), 64'(op));
      tick();
      check("op_resp_valid", 64'(resp_valid), 64'(onehot(r)));
      check("op_resp_w", 64'(resp_w), 64'(exp[DW-1:0]));
      check("op_resp_zero", 64'(resp_zero), 64'(exp[DW]));
      res = {resp_zero, resp_w};
      resp_ready[r] = 1'b1;
      tick();
      resp_ready = '0;
      check("op_done_resp", 64'(resp_valid), 64'd0);
      check("op_done_busy", 64'(busy), 64'd0);
      m_ptr = (r + 1) % NREQ;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [DW:0]   res, exp0, exp1;
      logic [DW-1:0] a0, a1;
      logic [3:0]    ops[NREQ];
      logic [DW-1:0] as_[NREQ], bs_[NREQ];
      int cnt[NREQ];
      int cur, win, dly;
      logic [NREQ-1:0] vmask;

      req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_ctrl = '0;
      Reset_n = 1'b1;

      // Reset state, sampled while reset is held
      #3 Reset_n = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_alu_b", 64'(alu_b), 64'd0);
      check("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALU_AND));
      check("rst_resp_w", 64'(resp_w), 64'd0);
      check("rst_resp_zero", 64'(resp_zero), 64'd0);
      tick();
      Reset_n = 1'b1;
      m_ptr = 0;
      tick();

      // Step 1: requester 0 ADD
      run_op(0, ALU_ADD, 32'd5, 32'd7, 1'b0, res);
      check("t1_add", 64'(res), {31'd0, 1'b0, 32'd12});

      // Step 2: requester 1 SLT / SLTU / SUB
      run_op(1, ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b0, res);
      check("t2_slt", 64'(res[DW-1:0]), 64'd1);
      run_op(1, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0, res);
      check("t2_sltu", 64'(res[DW-1:0]), 64'd0);
      run_op(1, ALU_SUB, 32'd9, 32'd9, 1'b0, res);
      check("t2_sub_zero", 64'(res), {31'd0, 1'b1, 32'd0});

      // Step 3: both requesters hold valid and resp_ready continuously
      apply_reset();
      a0 = $urandom; a1 = $urandom;
      set_req(0, ALU_ADD, a0, 32'd1);
      set_req(1, ALU_XOR, a1, 32'h5A5A5A5A);
      req_valid = 2'b11; resp_ready = 2'b11;
      cnt[0] = 0; cnt[1] = 0; cur = 0;
      for (int c = 0; c < 18; c++) begin
         #1;
         if (c % 3 == 0) cur = m_ptr;
         check("t3_req_ready", 64'(req_ready), (c % 3 == 0) ? 64'(onehot(cur)) : 64'd0);
         check("t3_resp_valid", 64'(resp_valid), (c % 3 == 2) ? 64'(onehot(cur)) : 64'd0);
         if (c % 3 == 2) begin
            res = (cur == 0) ? ref_alu(ALU_ADD, a0, 32'd1) : ref_alu(ALU_XOR, a1, 32'h5A5A5A5A);
            check("t3_resp_w", 64'(resp_w), 64'(res[DW-1:0]));
            m_ptr = (cur + 1) % NREQ;
         end
         for (int i = 0; i < NREQ; i++) if (resp_valid[i]) cnt[i]++;
         tick();
      end
      req_valid = '0; resp_ready = '0;
      check("t3_count0", 64'(cnt[0]), 64'd3);
      check("t3_count1", 64'(cnt[1]), 64'd3);

      // Step 4: backpressure on requester 0, then requester 1 wins next
      apply_reset();
      a0 = $urandom; a1 = $urandom;
      exp0 = ref_alu(ALU_XOR, a0, 32'h0F0F0F0F);
      exp1 = ref_alu(ALU_OR, a1, 32'h00FF0000);
      set_req(0, ALU_XOR, a0, 32'h0F0F0F0F);
      set_req(1, ALU_OR, a1, 32'h00FF0000);
      req_valid = 2'b11;
      #1;
      check("t4_first_grant", 64'(req_ready), 64'b01);
      tick();
      tick();
      for (int c = 0; c < 10; c++) begin
         resp_ready = 2'b10;
         #1;
         check("t4_hold_resp_valid", 64'(resp_valid), 64'b01);
         check("t4_hold_resp_w", 64'(resp_w), 64'(exp0[DW-1:0]));
         check("t4_hold_alu_a", 64'(alu_a), 64'(a0));
         check("t4_hold_req_ready", 64'(req_ready), 64'd0);
         tick();
      end
      resp_ready = 2'b01;
      tick();
      resp_ready = '0;
      #1;
      check("t4_next_grant", 64'(req_ready), 64'b10);
      tick();
      req_valid = '0;
      resp_ready = 2'b10;
      tick();
      check("t4_r1_valid", 64'(resp_valid), 64'b10);
      check("t4_r1_w", 64'(resp_w), 64'(exp1[DW-1:0]));
      tick();
      resp_ready = '0;
      m_ptr = 0;

      // Step 5: reset asserted during EXEC aborts the op
      apply_reset();
      set_req(0, ALU_ADD, 32'h12345678, 32'h1);
      req_valid = 2'b01;
      tick();
      #1 Reset_n = 1'b0;
      #1;
      check("t5_rst_req_ready", 64'(req_ready), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_resp_valid", 64'(resp_valid), 64'd0);
      check("t5_rst_alu_a", 64'(alu_a), 64'd0);
      check("t5_rst_resp_w", 64'(resp_w), 64'd0);
      req_valid = '0;
      tick();
      Reset_n = 1'b1;
      m_ptr = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("t5_no_resp", 64'(resp_valid), 64'd0);
         check("t5_idle", 64'(busy), 64'd0);
         tick();
      end
      run_op(1, ALU_NOR, 32'h0, 32'h0, 1'b0, res);

      // Step 6: sweep all 16 codes
      for (int op = 0; op < 16; op++) begin
         run_op(0, 4'(op), 32'd4, 32'h80000001, op[0], res);
         if (op == 13) check("t6_sra", 64'(res[DW-1:0]), 64'hF8000000);
         if (op == 14) check("t6_lui", 64'(res[DW-1:0]), 64'h00010000);
         if (op == 5)  check("t6_undef", 64'(res), {31'd0, 1'b1, 32'd0});
      end

      // Random phase: contention, dropped losers, delayed and stray resp_ready
      for (int t = 0; t < 30; t++) begin
         vmask = NREQ'($urandom_range(1, 3));
         for (int i = 0; i < NREQ; i++) begin
            ops[i] = 4'($urandom_range(0, 15));
            as_[i] = $urandom;
            bs_[i] = ($urandom_range(0, 3) == 0) ? as_[i] : $urandom;
            set_req(i, ops[i], as_[i], bs_[i]);
         end
         win = -1;
         for (int k = NREQ - 1; k >= 0; k--)
            if (vmask[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
         exp_q.push_back(ref_alu(ops[win], as_[win], bs_[win]));
         req_valid = vmask;
         #1;
         check("rnd_grant", 64'(req_ready), 64'(onehot(win)));
         tick();
         req_valid = '0;
         tick();
         dly = $urandom_range(0, 4);
         for (int j = 0; j < dly; j++) begin
            resp_ready = NREQ'($urandom) & ~onehot(win);
            #1;
            check("rnd_wait_valid", 64'(resp_valid), 64'(onehot(win)));
            tick();
         end
         resp_ready = onehot(win);
         #1;
         res = exp_q.pop_front();
         check("rnd_resp_valid", 64'(resp_valid), 64'(onehot(win)));
         check("rnd_resp_w", 64'(resp_w), 64'(res[DW-1:0]));
         check("rnd_resp_zero", 64'(resp_zero), 64'(res[DW]));
         tick();
         resp_ready = '0;
         check("rnd_done", 64'(busy), 64'd0);
         m_ptr = (win + 1) % NREQ;
      end

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
